// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the count PWM monitor
package counter_pkg;
    localparam int CNT_BITS = 4;
    localparam int DUTY_BITS = CNT_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
    typedef enum logic [2:0] {HOLD, INC, WRAP, RESTART, ERR} step_t;
    typedef logic [DUTY_BITS-1:0] duty_t;
    localparam duty_t DUTY_MAX = duty_t'(2 ** CNT_BITS);
    function automatic duty_t saturate_duty(input duty_t d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction
endpackage

// File: rtl/cnt_step_monitor.sv
// cnt_step_monitor: samples the count and classifies each step against the previous sample
module cnt_step_monitor import counter_pkg::*; #(
    parameter int CNT_W = CNT_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_q,
    output step_t            step
);
    logic [CNT_W-1:0] cnt_p;
    logic seen, hist_valid;
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            cnt_p <= '0;
            seen <= 1'b0;
            hist_valid <= 1'b0;
        end else begin
            cnt_q <= cnt_in;
            cnt_p <= cnt_q;
            seen <= en;
            hist_valid <= en && seen;
        end
    end
    // a drop to 0 from mid-count is the counter being reset, not a fault
    always_comb begin
        step = !hist_valid ? HOLD :
               cnt_q == cnt_p + CNT_W'(1) ? (cnt_q == '0 ? WRAP : INC) :
               cnt_q == cnt_p ? HOLD :
               (cnt_q == '0 && cnt_p != '1) ? RESTART : ERR;
    end
endmodule

// File: rtl/count_pwm_monitor.sv
// count_pwm_monitor: checks the counter sequence and drives PWM, wrap pulse and period tally
module count_pwm_monitor import counter_pkg::*; #(
    parameter int CNT_W = CNT_BITS,
    parameter int PER_W = 8,
    parameter int DUTY_W = DUTY_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic [PER_W-1:0]  period_cnt,
    output logic              seq_err,
    input  logic              err_clr
);
    logic [CNT_W-1:0] cnt_q;
    step_t step;
    state_t state, state_nxt;
    duty_t duty_act, shadow, duty_nxt;
    logic shadow_full, boundary, xfer, wrap_run, err_hit;
    cnt_step_monitor #(.CNT_W(CNT_W)) u_mon (
        .clk(clk),
        .reset(reset),
        .en(en),
        .cnt_in(cnt_in),
        .cnt_q(cnt_q),
        .step(step)
    );
    assign duty_ready = reset && !shadow_full;
    always_comb begin
        boundary = state != IDLE && en && (step == WRAP || step == RESTART);
        wrap_run = state == RUN && en && step == WRAP;
        err_hit = state != IDLE && step == ERR;
        xfer = duty_valid && duty_ready;
        duty_nxt = (boundary && shadow_full) ? shadow : duty_act;
        state_nxt = !en ? IDLE :
                    state == IDLE ? SYNC :
                    state == SYNC ? (boundary ? RUN : SYNC) :
                    (step == ERR ? SYNC : RUN);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            duty_act <= '0;
            shadow <= '0;
            shadow_full <= 1'b0;
            pwm_out <= 1'b0;
            wrap_pulse <= 1'b0;
            period_cnt <= '0;
            seq_err <= 1'b0;
        end else begin
            state <= state_nxt;
            duty_act <= duty_nxt;
            // ready is low while full, so a transfer never collides with a shadow load
            if (xfer) begin
                shadow <= saturate_duty(duty_t'(duty_in));
                shadow_full <= 1'b1;
            end else if (boundary) begin
                shadow_full <= 1'b0;
            end
            pwm_out <= state_nxt == RUN && duty_t'(cnt_q) < duty_nxt;
            wrap_pulse <= wrap_run;
            period_cnt <= period_cnt + PER_W'(wrap_run);
            seq_err <= err_hit || (seq_err && !err_clr);
        end
    end
endmodule

// File: tb/tb_count_pwm_monitor.sv
// tb_count_pwm_monitor: directed period table plus hand sequences for restart, errors and enable
module tb_count_pwm_monitor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic [3:0] cnt_in = '0;
    logic [4:0] duty_in = '0;
    logic duty_valid = 1'b0;
    logic err_clr = 1'b0;
    logic duty_ready, pwm_out, wrap_pulse, seq_err;
    logic [7:0] period_cnt;
    int nvec = 0;
    int nerr = 0;
    logic pend = 1'b0;
    logic exp_err = 1'b0;

    typedef struct {
        logic offer;
        int off_at;
        logic [4:0] dval;
        int n_high;
        logic wrap0;
        int per;
    } vec_t;
    vec_t tbl[12];

    count_pwm_monitor dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .cnt_in(cnt_in),
        .duty_in(duty_in),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .pwm_out(pwm_out),
        .wrap_pulse(wrap_pulse),
        .period_cnt(period_cnt),
        .seq_err(seq_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic [3:0] c);
        cnt_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input logic p, input logic w, input int per, input logic e);
        chk("pwm", pwm_out, p);
        chk("wrap", wrap_pulse, w);
        chk("period", period_cnt, per);
        chk("seq_err", seq_err, e);
    endtask

    // one period: drives counts 1..15,0 so outputs show counts 0..15
    task automatic run_vec(input vec_t v);
        logic acc;
        for (int i = 0; i < 16; i++) begin
            duty_valid = v.offer && i == v.off_at;
            duty_in = v.dval;
            acc = duty_valid && !pend;
            if (i == 0) pend = 1'b0;
            if (acc) pend = 1'b1;
            tick(4'(i + 1));
            duty_valid = 1'b0;
            exp_out(i < v.n_high, v.wrap0 && i == 0, v.per, exp_err);
            chk("ready", duty_ready, !pend);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 0, 5'd0,  4,  1'b0, 0};
        tbl[1]  = '{1'b0, 0, 5'd0,  4,  1'b1, 1};
        tbl[2]  = '{1'b1, 7, 5'd10, 4,  1'b1, 2};
        tbl[3]  = '{1'b0, 0, 5'd0,  10, 1'b1, 3};
        tbl[4]  = '{1'b1, 0, 5'd20, 10, 1'b1, 4};
        tbl[5]  = '{1'b0, 0, 5'd0,  16, 1'b1, 5};
        tbl[6]  = '{1'b1, 3, 5'd0,  16, 1'b1, 6};
        tbl[7]  = '{1'b0, 0, 5'd0,  0,  1'b1, 7};
        tbl[8]  = '{1'b1, 2, 5'd6,  0,  1'b1, 8};
        tbl[9]  = '{1'b0, 0, 5'd0,  6,  1'b1, 9};
        tbl[10] = '{1'b0, 0, 5'd0,  6,  1'b0, 10};
        tbl[11] = '{1'b0, 0, 5'd0,  6,  1'b0, 11};

        duty_valid = 1'b1;
        duty_in = 5'd4;
        tick(0);
        tick(0);
        exp_out(0, 0, 0, 0);
        chk("rst_ready", duty_ready, 0);
        duty_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("ready_after_rst", duty_ready, 1);
        duty_valid = 1'b1;
        duty_in = 5'd4;
        tick(0);
        duty_valid = 1'b0;
        chk("ready_full", duty_ready, 0);
        pend = 1'b1;
        en = 1'b1;
        for (int c = 8; c < 16; c++) begin
            tick(4'(c));
            chk("sync_pwm", pwm_out, 0);
        end
        tick(0);
        exp_out(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) run_vec(tbl[k]);

        // counter restart mid-period under duty 6
        for (int c = 1; c < 10; c++) begin
            tick(4'(c));
            exp_out((c - 1) < 6, c == 1, 10, 0);
        end
        tick(0);
        exp_out(0, 0, 10, 0);
        run_vec(tbl[10]);

        // illegal step 5->9, then error with clear, then clear alone
        tick(1);
        exp_out(1, 1, 11, 0);
        for (int c = 2; c < 6; c++) begin
            tick(4'(c));
            exp_out(1, 0, 11, 0);
        end
        tick(9);
        exp_out(1, 0, 11, 0);
        tick(10);
        exp_out(0, 0, 11, 1);
        tick(3);
        exp_out(0, 0, 11, 1);
        err_clr = 1'b1;
        tick(4);
        exp_out(0, 0, 11, 1);
        tick(5);
        exp_out(0, 0, 11, 0);
        err_clr = 1'b0;
        for (int c = 6; c < 16; c++) begin
            tick(4'(c));
            exp_out(0, 0, 11, 0);
        end
        tick(0);
        exp_out(0, 0, 11, 0);
        run_vec(tbl[11]);

        // long run through the tally wrap 255->0
        for (int k = 0; k < 250; k++) begin
            vec_t v;
            v = '{1'b0, 0, 5'd0, 6, 1'b1, (12 + k) % 256};
            run_vec(v);
        end

        // enable drop mid-period
        tick(1);
        exp_out(1, 1, 6, 0);
        en = 1'b0;
        tick(2);
        exp_out(0, 0, 6, 0);
        tick(3);
        exp_out(0, 0, 6, 0);

        // reset discards a pending shadow value
        duty_valid = 1'b1;
        duty_in = 5'd16;
        tick(0);
        duty_valid = 1'b0;
        chk("ready_pending", duty_ready, 0);
        reset = 1'b0;
        tick(0);
        exp_out(0, 0, 0, 0);
        chk("ready_in_rst", duty_ready, 0);
        reset = 1'b1;
        #1;
        chk("ready_shadow_cleared", duty_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
